regfile_32x32: RTL and testbench

REGFILE_32X32 -- requirements
Module: regfile_32x32

---
 rtl/regfile_32x32.sv | 73 +++++++
 tb/tb_regfile_32x32.sv | 133 +++++++++++++
 2 files changed

// File: rtl/regfile_32x32.sv
// 32-entry register file with a hardwired-zero R0, two combinational read
// ports and optional same-cycle write forwarding.

module regfile_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (we_i) data_d = d_i;
    end

    always_ff @(posedge clk) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign q_o = data_q;
endmodule

module regfile_32x32 #(
    parameter int WIDTH  = 32,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    output logic [31:0]      WriteEnableVec
);
    logic [31:0][WIDTH-1:0] rf_q;
    logic                   fwd_ok;
    logic                   byp1, byp2;

    always_comb begin
        WriteEnableVec = '0;
        if (!reset && RegWrite) WriteEnableVec[WriteRegister] = 1'b1;
        WriteEnableVec[0] = 1'b0;
    end

    // R0 has no storage; reads of index 0 see the constant.
    assign rf_q[0] = '0;

    for (genvar n = 1; n < 32; n++) begin : g_reg
        regfile_cell #(.WIDTH(WIDTH)) u_cell (
            .clk   (clk),
            .reset (reset),
            .we_i  (WriteEnableVec[n]),
            .d_i   (WriteData),
            .q_o   (rf_q[n])
        );
    end

    // Forward only a write that will actually land this edge.
    assign fwd_ok = (BYPASS != 0) && !reset && RegWrite && (WriteRegister != 5'd0);
    assign byp1   = fwd_ok && (WriteRegister == ReadRegister1);
    assign byp2   = fwd_ok && (WriteRegister == ReadRegister2);

    assign ReadData1 = byp1 ? WriteData : rf_q[ReadRegister1];
    assign ReadData2 = byp2 ? WriteData : rf_q[ReadRegister2];
endmodule

// File: tb/tb_regfile_32x32.sv
// Directed plus random bench for regfile_32x32; a bypassed and a non-bypassed
// instance share stimulus and are checked against an array model.

module tb_regfile_32x32;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        RegWrite = 1'b0;
    logic [4:0]  WriteRegister = '0;
    logic [31:0] WriteData = '0;
    logic [4:0]  ReadRegister1 = '0;
    logic [4:0]  ReadRegister2 = '0;
    logic [31:0] rd1_b, rd2_b, wev_b;
    logic [31:0] rd1_n, rd2_n, wev_n;

    int errors = 0;
    int checks = 0;
    logic [31:0] model [32];

    always #5 clk = ~clk;

    regfile_32x32 #(.WIDTH(32), .BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_b), .ReadData2(rd2_b), .WriteEnableVec(wev_b)
    );

    regfile_32x32 #(.WIDTH(32), .BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rd1_n), .ReadData2(rd2_n), .WriteEnableVec(wev_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected read value straight from the rules: index 0 reads zero; a live
    // write to the same nonzero index is forwarded when bypass is on.
    function automatic logic [31:0] exp_rd(input bit byp, input bit rst, input bit we,
                                           input logic [4:0] wr, input logic [31:0] wd,
                                           input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (byp && !rst && we && wr == idx) return wd;
        return model[idx];
    endfunction

    task automatic cyc(input bit rst, input bit we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input bit do_chk);
        logic [31:0] wev_exp;
        reset = rst; RegWrite = we; WriteRegister = wr; WriteData = wd;
        ReadRegister1 = r1; ReadRegister2 = r2;
        @(negedge clk);
        wev_exp = (rst || !we || wr == 5'd0) ? 32'h0 : (32'h1 << wr);
        if (do_chk) begin
            chk("wev_byp",   wev_b, wev_exp);
            chk("wev_nobyp", wev_n, wev_exp);
            chk("rd1_byp",   rd1_b, exp_rd(1'b1, rst, we, wr, wd, r1));
            chk("rd2_byp",   rd2_b, exp_rd(1'b1, rst, we, wr, wd, r2));
            chk("rd1_nobyp", rd1_n, exp_rd(1'b0, rst, we, wr, wd, r1));
            chk("rd2_nobyp", rd2_n, exp_rd(1'b0, rst, we, wr, wd, r2));
        end
        @(posedge clk);
        if (rst) for (int k = 0; k < 32; k++) model[k] = 32'h0;
        else if (we && wr != 5'd0) model[wr] = wd;
        #1;
    endtask

    initial begin
        logic [4:0]  wr, r1, r2;
        logic [31:0] wd;
        bit          rst, we;
        for (int k = 0; k < 32; k++) model[k] = 32'h0;
        @(posedge clk); #1;

        // reset for one edge, then scan every index on both ports
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 32; i++)
            cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b1);

        // write/readback
        cyc(1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd0, 5'd1, 1'b1);
        cyc(1'b0, 1'b1, 5'd31, 32'h12345678, 5'd0, 5'd1, 1'b1);
        cyc(1'b0, 1'b0, 5'd0,  32'h0,        5'd5, 5'd31, 1'b1);
        chk("r5_direct",  rd1_n, 32'hDEADBEEF);
        chk("r31_direct", rd2_n, 32'h12345678);

        // R0 protection, then readback of index 0
        cyc(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1);
        cyc(1'b0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1);

        // same-cycle bypass on both ports
        cyc(1'b0, 1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0, 1'b1);
        cyc(1'b0, 1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7, 1'b1);
        cyc(1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b1);

        // reset versus write on the same edge; bypass suppressed under reset
        cyc(1'b0, 1'b1, 5'd9, 32'h55AA55AA, 5'd9, 5'd5, 1'b1);
        cyc(1'b1, 1'b1, 5'd9, 32'hABCD0000, 5'd9, 5'd9, 1'b1);
        for (int i = 0; i < 32; i++)
            cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i ^ 7), 1'b1);

        // reset pulse between edges must not disturb contents
        cyc(1'b0, 1'b1, 5'd12, 32'hCAFEF00D, 5'd0, 5'd0, 1'b1);
        RegWrite = 1'b0; ReadRegister1 = 5'd12;
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd12, 1'b1);

        // exhaustive decode, with and without RegWrite
        for (int n = 0; n < 32; n++) begin
            cyc(1'b0, 1'b1, 5'(n), 32'h1000_0000 + n, 5'(n), 5'(n + 1), 1'b1);
            cyc(1'b0, 1'b0, 5'(n), 32'hFFFF_0000 + n, 5'(n), 5'(n - 1), 1'b1);
        end

        // random traffic, reads biased toward the write target
        for (int t = 0; t < 400; t++) begin
            rst = ($urandom_range(0, 24) == 0);
            we  = ($urandom_range(0, 3) != 0);
            wr  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            r1  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
            r2  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
            cyc(rst, we, wr, wd, r1, r2, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
